// File: rtl/block_fifo_gearbox.sv
// block_fifo_gearbox
//   Packs WORDS consecutive WORD_W-bit words into one BLOCK_W-bit block and
//   queues complete blocks in a DEPTH-entry FIFO for a block-wide consumer.
//
// Ports
//   HCLK          single clock, rising edge
//   HRESETn       synchronous active-low reset
//   flush         drop the partial block and every queued block
//   err_clr       clear overflow_err (a same-cycle set wins)
//   wr_valid      wr_data holds a word
//   wr_data       one word; first word of a block lands in the MSB slice
//   wr_ready      a word offered this cycle is accepted
//   blk_valid     blk_data holds the FIFO head block
//   blk_data      FIFO head block
//   blk_ready     consumer takes the head block this cycle
//   count         number of complete blocks queued
//   word_idx      number of words held in the partial block
//   full, empty   count==DEPTH, count==0
//   overflow_err  sticky: a word was offered while wr_ready was low
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ready never depends combinationally on valid (or on the other
// side's ready); a word offered with wr_ready low is dropped and flagged.

module block_fifo_gearbox #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          flush,
    input  logic                          err_clr,
    input  logic                          wr_valid,
    input  logic [WORD_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          blk_valid,
    output logic [WORD_W*WORDS-1:0]       blk_data,
    input  logic                          blk_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [$clog2(WORDS)-1:0]      word_idx,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow_err
);

    localparam int BLOCK_W = WORD_W * WORDS;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int IDX_W   = $clog2(WORDS);

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [BLOCK_W-1:0] pack_q;
    logic [BLOCK_W-1:0] blk_in;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               last_word;
    logic               accept;
    logic               push;
    logic               pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign blk_valid = !empty;
    assign blk_data  = mem[rd_ptr];

    assign last_word = (word_idx == IDX_W'(WORDS - 1));
    // Only the word that completes a block needs a free FIFO slot; the
    // earlier words sit in the packer, so they are taken even when full.
    assign wr_ready  = !(last_word && full);
    assign accept    = wr_valid && wr_ready;
    assign push      = accept && last_word;
    assign pop       = blk_valid && blk_ready;

    // The last word occupies the lowest slice, so the pushed block is the
    // packer's upper slices with the incoming word appended.
    assign blk_in    = {pack_q[BLOCK_W-1:WORD_W], wr_data};

    // Data path: packer and storage carry no reset.
    always_ff @(posedge HCLK) begin
        if (HRESETn && !flush) begin
            if (accept) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (word_idx == IDX_W'(k)) begin
                        pack_q[BLOCK_W-1-k*WORD_W -: WORD_W] <= wr_data;
                    end
                end
            end
            if (push) begin
                mem[wr_ptr] <= blk_in;
            end
        end
    end

    // Control path
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            word_idx     <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                word_idx <= '0;
            end else begin
                if (accept) begin
                    word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            // A new overflow beats a simultaneous clear.
            if (wr_valid && !wr_ready) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/block_fifo_gearbox.md
BLOCK_FIFO_GEARBOX -- requirements
Module: block_fifo_gearbox

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the bus-side word width in bits.
REQ-002 Parameter WORDS, default 4, SHALL set words per block (>=2); BLOCK_W = WORD_W*WORDS (default 128).
REQ-003 Parameter DEPTH, default 4, SHALL set FIFO depth in blocks (power of two, >=2).
REQ-004 HCLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 HRESETn  input  1  SHALL be the reset, synchronous, active-low.
REQ-006 flush  input  1  SHALL discard the partial block and all queued blocks.
REQ-007 err_clr  input  1  SHALL clear overflow_err.
REQ-008 wr_valid  input  1  SHALL qualify wr_data.
REQ-009 wr_data  input  WORD_W  SHALL carry one word of a block.
REQ-010 wr_ready  output  1  SHALL indicate a word is accepted this cycle if wr_valid is high.
REQ-011 blk_valid  output  1  SHALL indicate blk_data holds the FIFO head block.
REQ-012 blk_data  output  BLOCK_W  SHALL carry the FIFO head block.
REQ-013 blk_ready  input  1  SHALL indicate the consumer takes the head block this cycle.
REQ-014 count  output  clog2(DEPTH+1)  SHALL report queued complete blocks.
REQ-015 word_idx  output  clog2(WORDS)  SHALL report words held in the partial block.
REQ-016 full, empty  output  1 each  SHALL equal (count==DEPTH) and (count==0).
REQ-017 overflow_err  output  1  SHALL be a sticky flag for words offered while wr_ready low.

Function
REQ-018 Word accepted = wr_valid && wr_ready; block popped = blk_valid && blk_ready.
REQ-019 First accepted word of a block SHALL land in blk_data[BLOCK_W-1 -: WORD_W]; word k in the k-th slice down from MSB.
REQ-020 word_idx SHALL increment per accepted word and wrap WORDS-1 -> 0 on the last word.
REQ-021 Accepting the last word SHALL push the assembled block (last word included) into the FIFO at the same edge; blk_valid SHALL rise the following cycle if FIFO was empty (latency 1 cycle from last word).
REQ-022 wr_ready SHALL be registered-state only: low iff word_idx==WORDS-1 and full; no combinational path from blk_ready or wr_valid.
REQ-023 Words 0..WORDS-2 SHALL be accepted even when full (held in packer register).
REQ-024 wr_valid && !wr_ready SHALL drop the word, leave all data state unchanged, set overflow_err next edge.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Pop when empty SHALL be impossible (blk_valid=0); blk_ready then ignored.
REQ-027 blk_data SHALL stay stable while blk_valid && !blk_ready.
REQ-028 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 flush SHALL, at the edge, zero pointers, count, word_idx; accept/pop in that cycle SHALL be ignored; overflow_err unaffected.
REQ-030 err_clr SHALL zero overflow_err; if a set occurs the same cycle, set wins.
REQ-031 Priority: HRESETn low > flush > normal operation.

Reset
REQ-032 With HRESETn low at an edge: count=0, word_idx=0, pointers=0, overflow_err=0, blk_valid=0, empty=1, full=0, wr_ready=1.
REQ-033 FIFO storage and packer data need not be reset; blk_data is don't-care while blk_valid=0.
REQ-034 Reset mid-block SHALL discard the partial block; first word after release is word 0.

Verification
REQ-035 Defaults: write 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF -> next cycle blk_valid=1, blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, count=1.
REQ-036 blk_ready=0, write 5 blocks -> after 4, full=1; 5th block words 0-2 accepted, word 3 wr_ready=0; word 3 held -> overflow_err=0; word 3 forced with wr_valid -> overflow_err=1, count=4.
REQ-037 Full, word_idx=3, pulse blk_ready one cycle -> count=3, wr_ready=1 next cycle; word 3 accepted -> count=4, order preserved.
REQ-038 Continuous stream with blk_ready=1 -> count toggles 0/1, no overflow, blocks emerge in order, pointers wrap past DEPTH.
REQ-039 Two words written, then flush -> word_idx=0, count=0, empty=1; next 4 words form a clean block.
REQ-040 overflow_err=1, err_clr asserted with a new overflow same cycle -> overflow_err stays 1; err_clr alone next -> 0.
